// File: rtl/sat_down_ctr.sv
// Saturating down-counter with one-cycle expiry pulse and sticky illegal-load flag.
//
// Counts from MAX down to 0 and holds at 0. Reset or ctr_rst reloads MAX.
// A 2-bit FULL/RUN/EMPTY state register tracks the count region and always
// agrees with out.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   ctr_rst  in   synchronous reload to MAX, clears err
//   en       in   decrement enable
//   ld       in   load ld_val this cycle
//   ld_val   in   [WIDTH] value to load (legal when <= MAX)
//   out      out  [WIDTH] current count (registered)
//   zero     out  combinational (out == 0)
//   done     out  registered pulse, one cycle after a decrement from 1 to 0
//   err      out  registered sticky illegal-load flag

// Plain synchronous-reset register cell; every flop of the counter uses it.
module sat_down_ctr_dff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

module sat_down_ctr #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctr_rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    typedef enum logic [1:0] {
        FULL  = 2'd0,
        RUN   = 2'd1,
        EMPTY = 2'd2
    } state_t;

    state_t           st_q;
    state_t           st_n;
    logic [1:0]       st_raw;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_n;
    logic             done_q;
    logic             done_n;
    logic             err_q;
    logic             err_n;

    // Region of the count space a given value falls into.
    function automatic state_t classify(input logic [WIDTH-1:0] v);
        if (v == '0)         return EMPTY;
        else if (v == MAX_V) return FULL;
        else                 return RUN;
    endfunction

    // State register and datapath flops; rst dominates inside the cell.
    sat_down_ctr_dff #(.WIDTH(2), .RST_VAL(2'(FULL))) u_state (
        .clk (clk), .rst (rst), .d (2'(st_n)), .q (st_raw)
    );

    sat_down_ctr_dff #(.WIDTH(WIDTH), .RST_VAL(MAX_V)) u_out (
        .clk (clk), .rst (rst), .d (out_n), .q (out_q)
    );

    sat_down_ctr_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_done (
        .clk (clk), .rst (rst), .d (done_n), .q (done_q)
    );

    sat_down_ctr_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_err (
        .clk (clk), .rst (rst), .d (err_n), .q (err_q)
    );

    assign st_q = state_t'(st_raw);

    // Next-state and next-output logic: ctr_rst > ld > en > hold.
    always_comb begin
        st_n   = st_q;
        out_n  = out_q;
        done_n = 1'b0;
        err_n  = err_q;

        if (ctr_rst) begin
            st_n  = FULL;
            out_n = MAX_V;
            err_n = 1'b0;
        end else if (ld) begin
            // Illegal values leave the count untouched and only flag err.
            if (ld_val <= MAX_V) begin
                out_n = ld_val;
                st_n  = classify(ld_val);
            end else begin
                err_n = 1'b1;
            end
        end else if (en) begin
            case (st_q)
                FULL, RUN: begin
                    out_n = out_q - ONE_V;
                    if (out_q == ONE_V) begin
                        st_n   = EMPTY;
                        done_n = 1'b1;
                    end else begin
                        st_n   = RUN;
                    end
                end
                EMPTY:   st_n = EMPTY;
                default: st_n = classify(out_q);
            endcase
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign err  = err_q;
    assign zero = (out_q == '0);

endmodule

// File: tb/tb_sat_down_ctr.sv
module tb_sat_down_ctr;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned MAX   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ctr_rst = 1'b0;
    logic             en = 1'b0;
    logic             ld = 1'b0;
    logic [WIDTH-1:0] ld_val = '0;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             done;
    logic             err;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             zero;
        logic             done;
        logic             err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state (integer arithmetic, independent of RTL encoding).
    int m_out  = MAX;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    sat_down_ctr #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctr_rst (ctr_rst),
        .en      (en),
        .ld      (ld),
        .ld_val  (ld_val),
        .out     (out),
        .zero    (zero),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, push the model's expectation, and return
    // just after the capturing edge.
    task automatic cyc(input logic r, input logic cr, input logic l,
                       input logic [WIDTH-1:0] lv, input logic en_i);
        exp_t x;
        @(negedge clk);
        rst = r; ctr_rst = cr; ld = l; ld_val = lv; en = en_i;
        if (r || cr) begin
            m_out = MAX; m_done = 0; m_err = 0;
        end else if (l) begin
            m_done = 0;
            if (int'(lv) <= MAX) m_out = int'(lv);
            else                 m_err = 1;
        end else if (en_i) begin
            m_done = (m_out == 1);
            if (m_out > 0) m_out = m_out - 1;
        end else begin
            m_done = 0;
        end
        x.out  = WIDTH'(m_out);
        x.zero = (m_out == 0);
        x.done = m_done;
        x.err  = m_err;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        e = sb.pop_front();
        n_checks++;
        if ({out, zero, done, err} !== {3'd5, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset: out=%0d zero=%b done=%b err=%b want out=5 zero=0 done=0 err=0",
                     out, zero, done, err);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            e = sb.pop_front();
            n_checks++;
            if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
                $display("FAIL reset_idle[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                         out, zero, done, err, e.out, e.zero, e.done, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_countdown();
        logic [WIDTH-1:0] seq [7];
        logic             dn  [7];
        seq = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        dn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        cyc(1, 0, 0, 0, 0);
        e = sb.pop_front();
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 1);
            e = sb.pop_front();
            n_checks++;
            if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
                $display("FAIL countdown_model[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                         out, zero, done, err, e.out, e.zero, e.done, e.err);
            else n_pass++;
            n_checks++;
            if ({out, done, zero, err} !== {seq[i], dn[i], (seq[i] == 3'd0), 1'b0})
                $display("FAIL countdown_seq[%0d]: out=%0d done=%b zero=%b err=%b want out=%0d done=%b",
                         i, out, done, zero, err, seq[i], dn[i]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal_load();
        cyc(1, 0, 0, 0, 0);
        e = sb.pop_front();
        cyc(0, 0, 0, 0, 1);
        e = sb.pop_front();
        cyc(0, 0, 0, 0, 1);
        e = sb.pop_front();
        // ld of 6 with en also high: out must hold at 3
        cyc(0, 0, 1, 3'd6, 1);
        e = sb.pop_front();
        n_checks++;
        if ({out, err, done} !== {3'd3, 1'b1, 1'b0})
            $display("FAIL illegal_load: out=%0d err=%b done=%b want out=3 err=1 done=0", out, err, done);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, i == 1);
            e = sb.pop_front();
            n_checks++;
            if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
                $display("FAIL err_sticky[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                         out, zero, done, err, e.out, e.zero, e.done, e.err);
            else n_pass++;
        end
        cyc(0, 0, 1, 3'd7, 0);
        e = sb.pop_front();
        n_checks++;
        if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
            $display("FAIL illegal_load7: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                     out, zero, done, err, e.out, e.zero, e.done, e.err);
        else n_pass++;
        cyc(0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_checks++;
        if ({out, err} !== {3'd5, 1'b0})
            $display("FAIL ctr_rst_clears_err: out=%0d err=%b want out=5 err=0", out, err);
        else n_pass++;
    endtask

    task automatic test_load_priority();
        cyc(1, 0, 0, 0, 0);
        e = sb.pop_front();
        cyc(0, 0, 0, 0, 1);
        e = sb.pop_front();
        cyc(0, 0, 1, 3'd2, 1);
        e = sb.pop_front();
        n_checks++;
        if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
            $display("FAIL ld_over_en: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                     out, zero, done, err, e.out, e.zero, e.done, e.err);
        else n_pass++;
        cyc(0, 0, 0, 0, 1);
        e = sb.pop_front();
        n_checks++;
        if (out !== 3'd1)
            $display("FAIL ld_then_en: out=%0d want 1", out);
        else n_pass++;
        // ld of MAX is the legal boundary
        cyc(0, 0, 1, 3'd5, 0);
        e = sb.pop_front();
        n_checks++;
        if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
            $display("FAIL ld_max: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                     out, zero, done, err, e.out, e.zero, e.done, e.err);
        else n_pass++;
    endtask

    task automatic test_load_zero();
        cyc(0, 0, 1, 3'd0, 0);
        e = sb.pop_front();
        n_checks++;
        if ({out, zero, done} !== {3'd0, 1'b1, 1'b0})
            $display("FAIL ld_zero: out=%0d zero=%b done=%b want out=0 zero=1 done=0", out, zero, done);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            e = sb.pop_front();
            n_checks++;
            if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
                $display("FAIL saturate[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                         out, zero, done, err, e.out, e.zero, e.done, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 1, 3'd1, 0);
            e = sb.pop_front();
            cyc(k == 0, k == 1, 0, 0, 1);
            e = sb.pop_front();
            n_checks++;
            if ({out, done, zero} !== {3'd5, 1'b0, 1'b0})
                $display("FAIL reset_mid[%0d]: out=%0d done=%b zero=%b want out=5 done=0 zero=0",
                         k, out, done, zero);
            else n_pass++;
        end
        // pending done pulse cancelled by ctr_rst
        cyc(0, 0, 1, 3'd1, 0);
        e = sb.pop_front();
        cyc(0, 0, 0, 0, 1);
        e = sb.pop_front();
        n_checks++;
        if ({out, done} !== {3'd0, 1'b1})
            $display("FAIL expiry_pulse: out=%0d done=%b want out=0 done=1", out, done);
        else n_pass++;
        cyc(0, 1, 0, 0, 1);
        e = sb.pop_front();
        n_checks++;
        if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
            $display("FAIL pulse_cancel: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                     out, zero, done, err, e.out, e.zero, e.done, e.err);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 5) == 0, WIDTH'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0);
            e = sb.pop_front();
            n_checks++;
            if ({out, zero, done, err} !== {e.out, e.zero, e.done, e.err})
                $display("FAIL random[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                         out, zero, done, err, e.out, e.zero, e.done, e.err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_illegal_load();
        test_load_priority();
        test_load_zero();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sat_down_ctr.md
Name: sat_down_ctr

Overview:
- Saturating down-counter; the counterpart to the team's saturating up-counter `sc`, which counts 0 to 5 and holds at 5.
- Resets and reloads to MAX, decrements on enable, and holds at 0.
- Emits a one-cycle done pulse on arrival at 0 and a sticky err on an illegal load.
- Used as a countdown/credit timer beside `sc` in the hw3 datapath.

Parameters:
- WIDTH, 3, counter width in bits.
- MAX, 5, reload/reset value and upper legal bound. Must satisfy 1 <= MAX <= 2^WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ctr_rst  input  1  synchronous reload to MAX; clears err.
- en  input  1  decrement enable.
- ld  input  1  load ld_val this cycle.
- ld_val  input  WIDTH  value to load.
- out  output  WIDTH  current count.
- zero  output  1  combinational, (out == 0).
- done  output  1  registered pulse; high for exactly one cycle after a decrement from 1 to 0.
- err  output  1  registered, sticky illegal-load flag.

Behaviour:
- All flops are built from the codebase dff cell (sync reset). No latches and no async logic.
- Reset (rst=1 at an edge): out=MAX, state=FULL, done=0, err=0. zero then reads 0.
- Next-state priority per edge: rst > ctr_rst > ld > en > hold.
- ctr_rst=1:
  - out=MAX, state=FULL, done=0, err=0.
  - Any ld/en in the same cycle is ignored.
- ld=1 with ld_val <= MAX:
  - out=ld_val; state follows the value (0 -> EMPTY, MAX -> FULL, else RUN).
  - done=0. err is unchanged.
  - en in the same cycle is ignored.
- ld=1 with ld_val > MAX:
  - out and state unchanged; err set to 1 (sticky); done=0.
  - en in the same cycle is also ignored.
- en=1, no higher-priority input, out > 0:
  - out = out-1, computed mod 2^WIDTH but never wraps, because out > 0.
  - If out was 1: state -> EMPTY and done=1 for the next cycle only.
  - Otherwise state -> RUN and done=0.
- en=1 at out=0:
  - out stays 0; saturation is legal, not an error. done=0.
- Idle (no inputs active): out and err hold; done=0.
- State machine is a 2-bit register:
  - FULL (out==MAX), RUN (0<out<MAX), EMPTY (out==0).
  - Transitions: FULL -en-> RUN (or EMPTY if MAX==1); RUN -en-> RUN/EMPTY; EMPTY -en-> EMPTY.
  - Any state -ld-> per value; any state -rst/ctr_rst-> FULL.
  - State must always agree with out. A mismatch is a design bug and must never be reachable.
- Latency:
  - out, done and err reflect inputs sampled at edge N from edge N onward (one register stage).
  - zero is combinational from out.
- Reset mid-count: rst or ctr_rst during any state immediately restores the reset values above. A pending done is cancelled.
- Load of 0 never raises done. done only indicates a counted-down expiry.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, then all inputs 0 -> out=5, zero=0, done=0, err=0, stable for 5 cycles.
- Countdown: rst, then en=1 for 7 cycles:
  - out sequence 5,4,3,2,1,0,0,0;
  - done=1 only in the cycle out first reads 0;
  - zero=1 from that cycle on; err=0 throughout.
- Illegal load:
  - at out=3, ld=1 with ld_val=6 -> out stays 3, err=1 and stays 1;
  - then ctr_rst=1 -> out=5, err=0.
- Legal load with priority: at out=4, ld=1, ld_val=2, en=1 -> out=2 (en ignored); next cycle en=1 -> out=1.
- Load zero / saturation: ld=1 with ld_val=0 -> out=0, zero=1, done=0; then en=1 for 3 cycles -> out=0, done=0, err=0.
- Reset mid-operation: from out=1, assert rst and en together -> out=5, done=0 (no expiry pulse). Repeat with ctr_rst instead of rst -> same result.
